char_frame_ctrl: RTL and testbench
==================================

# char_frame_ctrl

Frame-synchronous controller for the character position and animation inputs of the pixel generator. It accepts position updates from game logic over a valid/ready handshake, holds them in a shadow register, and commits them only at the start of vertical blanking, so the pixel generator never sees the character move mid-frame. It also maintains a free-running frame counter and an animation frame index for the character sprite ROM.

## Interface
- SCREEN_WIDTH, 10, width of x/y coordinates
- V_ACTIVE, 480, first non-visible line; the line at which vertical blanking starts
- H_ACTIVE, 640, visible pixels per line
- CHAR_WIDTH_X, 32, character width in pixels
- CHAR_WIDTH_Y, 32, character height in pixels
- INIT_X, 304, reset value of char_x
- INIT_Y, 224, reset value of char_y
- FRAME_CNT_WIDTH, 16, frame counter width
- ANIM_FRAMES, 4, number of animation frames (≥2)
- ANIM_DIV, 8, frames per animation step (≥1)

Ports:
- sys_clk  in  1  system clock; the only clock in the block
- sys_rst_n  in  1  reset, asynchronous and active-low
- y  in  SCREEN_WIDTH  current scan line from the VGA controller
- upd_valid  in  1  position update offered
- upd_ready  out  1  controller can accept an update
- upd_char_x  in  SCREEN_WIDTH  requested character x (top-left)
- upd_char_y  in  SCREEN_WIDTH  requested character y (top-left)
- char_x  out  SCREEN_WIDTH  committed character x to the pixel generator
- char_y  out  SCREEN_WIDTH  committed character y to the pixel generator
- commit_pulse  out  1  one-cycle pulse when a new position is committed
- frame_cnt  out  FRAME_CNT_WIDTH  frames elapsed since reset
- anim_idx  out  clog2(ANIM_FRAMES)  current animation frame index

## Operation
- blank = (y >= V_ACTIVE), combinational. blank_d is the registered blank, reset to 1. vb_start = blank & ~blank_d.
- Consequence: releasing reset during blanking produces no vb_start until the next frame.
- States: IDLE (shadow empty), PENDING (shadow holds an uncommitted update).
- IDLE: upd_ready=1. When upd_valid & upd_ready, load the clamped update into the shadow and go to PENDING.
- PENDING: upd_ready=0; upd_valid is ignored.
- PENDING & vb_start: char_x/char_y <= shadow, commit_pulse <= 1, go to IDLE.
- IDLE & vb_start: outputs unchanged, commit_pulse stays 0.
- Simultaneous accept and vb_start while in IDLE: the update is accepted but not committed on that edge; it commits at the next frame's vb_start.
- Clamping is applied at acceptance, with unsigned compares:
  - shadow_x = min(upd_char_x, H_ACTIVE − CHAR_WIDTH_X)
  - shadow_y = min(upd_char_y, V_ACTIVE − CHAR_WIDTH_Y)
- Frame counter: on every vb_start, frame_cnt <= frame_cnt + 1, wrapping modulo 2^FRAME_CNT_WIDTH.
- Animation:
  - An internal divider counts vb_start events from 0 to ANIM_DIV−1.
  - When the divider wraps, anim_idx increments, wrapping from ANIM_FRAMES−1 to 0.
- Reset values (asynchronous, sys_rst_n low):
  - state = IDLE, upd_ready = 1
  - char_x = INIT_X, char_y = INIT_Y
  - commit_pulse = 0, frame_cnt = 0, anim_idx = 0
  - divider = 0, shadow = 0, blank_d = 1
- Reset mid-operation discards any pending update; the committed position returns to INIT.

## Timing
- upd_ready is a registered function of state. It falls on the clock edge that accepts an update, so at most one transfer is accepted per frame.
- Commit latency: char_x, char_y and commit_pulse change on the sys_clk edge at the end of the vb_start cycle. commit_pulse is high for exactly one cycle.
- frame_cnt, the divider and anim_idx update on that same edge.
- char_x and char_y are stable for all active-video lines (y < V_ACTIVE).
- vb_start is asserted for exactly one cycle per frame, regardless of how many sys_clk cycles y stays at V_ACTIVE.
- Worst-case update latency from acceptance to commit: one full frame plus one cycle.

## Test plan
- Reset release with y=100 → char_x=304, char_y=224, upd_ready=1, frame_cnt=0, anim_idx=0; no commit_pulse through the end of the first frame.
- Offer (100,50) at y=200 → accepted, upd_ready=0; when y steps 479→480, char_x=100 and char_y=50 one cycle later, commit_pulse high for one cycle, upd_ready=1.
- Offer (700,470) → committed as char_x=608, char_y=448 (clamped).
- Hold upd_valid with a new value every cycle for two frames → exactly one update accepted per frame; the second value offered while PENDING is never committed.
- Assert upd_valid in the vb_start cycle while IDLE → accepted, no commit that frame, committed at the next vb_start.
- Run 64 frames with ANIM_DIV=8, ANIM_FRAMES=4 → frame_cnt=64; anim_idx sequence 0,1,2,3,0,… changing every 8 frames, ending at 0. Then pulse sys_rst_n low mid-line while PENDING → all outputs return to reset values immediately and the pending update is lost.

Source files
------------

// File: rtl/char_frame_ctrl.sv
// Frame-synchronous character position controller: buffers one position update per frame
// and commits it at the start of vertical blanking, alongside frame and animation counters.
module char_frame_ctrl #(
    parameter int SCREEN_WIDTH    = 10,
    parameter int V_ACTIVE        = 480,
    parameter int H_ACTIVE        = 640,
    parameter int CHAR_WIDTH_X    = 32,
    parameter int CHAR_WIDTH_Y    = 32,
    parameter int INIT_X          = 304,
    parameter int INIT_Y          = 224,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int ANIM_FRAMES     = 4,
    parameter int ANIM_DIV        = 8
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic [SCREEN_WIDTH-1:0]        y,
    input  logic                           upd_valid,
    output logic                           upd_ready,
    input  logic [SCREEN_WIDTH-1:0]        upd_char_x,
    input  logic [SCREEN_WIDTH-1:0]        upd_char_y,
    output logic [SCREEN_WIDTH-1:0]        char_x,
    output logic [SCREEN_WIDTH-1:0]        char_y,
    output logic                           commit_pulse,
    output logic [FRAME_CNT_WIDTH-1:0]     frame_cnt,
    output logic [$clog2(ANIM_FRAMES)-1:0] anim_idx
);

    localparam int ANIM_W = $clog2(ANIM_FRAMES);
    localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [SCREEN_WIDTH-1:0] V_START  = SCREEN_WIDTH'(V_ACTIVE);
    localparam logic [SCREEN_WIDTH-1:0] MAX_X    = SCREEN_WIDTH'(H_ACTIVE - CHAR_WIDTH_X);
    localparam logic [SCREEN_WIDTH-1:0] MAX_Y    = SCREEN_WIDTH'(V_ACTIVE - CHAR_WIDTH_Y);
    localparam logic [SCREEN_WIDTH-1:0] RESET_X  = SCREEN_WIDTH'(INIT_X);
    localparam logic [SCREEN_WIDTH-1:0] RESET_Y  = SCREEN_WIDTH'(INIT_Y);
    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(ANIM_DIV - 1);
    localparam logic [ANIM_W-1:0]       ANIM_LAST = ANIM_W'(ANIM_FRAMES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    blank;
    logic                    blank_d;
    logic                    vb_start;
    logic                    accept;
    logic                    commit;
    logic [SCREEN_WIDTH-1:0] clamp_x;
    logic [SCREEN_WIDTH-1:0] clamp_y;
    logic [SCREEN_WIDTH-1:0] shadow_x;
    logic [SCREEN_WIDTH-1:0] shadow_y;
    logic [DIV_W-1:0]        div_cnt;

    // blank_d resets high so a reset released inside blanking waits for the next frame
    assign blank    = (y >= V_START);
    assign vb_start = blank & ~blank_d;

    assign clamp_x = (upd_char_x > MAX_X) ? MAX_X : upd_char_x;
    assign clamp_y = (upd_char_y > MAX_Y) ? MAX_Y : upd_char_y;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (upd_valid && upd_ready) begin
                    accept     = 1'b1;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (vb_start) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // upd_ready tracks the next state so it drops on the accepting edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            upd_ready <= 1'b1;
        end else begin
            state     <= state_next;
            upd_ready <= (state_next == IDLE);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blank_d <= 1'b1;
        end else begin
            blank_d <= blank;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_x <= '0;
            shadow_y <= '0;
        end else if (accept) begin
            shadow_x <= clamp_x;
            shadow_y <= clamp_y;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            char_x       <= RESET_X;
            char_y       <= RESET_Y;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= commit;
            if (commit) begin
                char_x <= shadow_x;
                char_y <= shadow_y;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt <= '0;
        end else if (vb_start) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Animation advances once every ANIM_DIV frames
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt  <= '0;
            anim_idx <= '0;
        end else if (vb_start) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                anim_idx <= (anim_idx == ANIM_LAST) ? '0 : anim_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_char_frame_ctrl.sv
// Randomized scoreboard bench for char_frame_ctrl: a frame-level reference model predicts
// commits, and a negedge monitor checks every commit_pulse against the expected queue.
module tb_char_frame_ctrl;

    localparam int SW       = 10;
    localparam int V_ACTIVE = 480;
    localparam int H_ACTIVE = 640;
    localparam int CW_X     = 32;
    localparam int CW_Y     = 32;
    localparam int INIT_X   = 304;
    localparam int INIT_Y   = 224;
    localparam int FCW      = 16;
    localparam int AF       = 4;
    localparam int AD       = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [SW-1:0] y = 10'd100;
    logic          upd_valid = 1'b0;
    logic [SW-1:0] upd_char_x = '0;
    logic [SW-1:0] upd_char_y = '0;
    logic          upd_ready;
    logic [SW-1:0] char_x;
    logic [SW-1:0] char_y;
    logic          commit_pulse;
    logic [FCW-1:0] frame_cnt;
    logic [1:0]    anim_idx;

    char_frame_ctrl #(
        .SCREEN_WIDTH(SW), .V_ACTIVE(V_ACTIVE), .H_ACTIVE(H_ACTIVE),
        .CHAR_WIDTH_X(CW_X), .CHAR_WIDTH_Y(CW_Y), .INIT_X(INIT_X), .INIT_Y(INIT_Y),
        .FRAME_CNT_WIDTH(FCW), .ANIM_FRAMES(AF), .ANIM_DIV(AD)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .y(y),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_char_x(upd_char_x), .upd_char_y(upd_char_y),
        .char_x(char_x), .char_y(char_y), .commit_pulse(commit_pulse),
        .frame_cnt(frame_cnt), .anim_idx(anim_idx)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int x;
        int y;
        int fc;
        int ai;
    } commit_t;

    commit_t exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference model state, expressed in frame-level terms
    bit pending;
    bit blank_prev;
    int shadow_x, shadow_y;
    int cur_x, cur_y;
    int vb_count;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        pending    = 1'b0;
        blank_prev = 1'b1;
        shadow_x   = 0;
        shadow_y   = 0;
        cur_x      = INIT_X;
        cur_y      = INIT_Y;
        vb_count   = 0;
        exp_q.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_upd_ready"}, upd_ready, 1);
        checkOutput({tag, "_char_x"}, char_x, INIT_X);
        checkOutput({tag, "_char_y"}, char_y, INIT_Y);
        checkOutput({tag, "_commit_pulse"}, commit_pulse, 0);
        checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
        checkOutput({tag, "_anim_idx"}, anim_idx, 0);
    endtask

    // Drive one cycle of inputs and advance the model by that cycle
    task automatic driveCycle(input int yy, input bit v, input int ux, input int uy);
        bit blank, vb, was_pending;
        commit_t c;
        y          = SW'(yy);
        upd_valid  = v;
        upd_char_x = SW'(ux);
        upd_char_y = SW'(uy);
        blank       = (yy >= V_ACTIVE);
        vb          = blank && !blank_prev;
        blank_prev  = blank;
        was_pending = pending;
        if (vb) begin
            vb_count++;
            if (was_pending) begin
                cur_x   = shadow_x;
                cur_y   = shadow_y;
                pending = 1'b0;
                c.x  = cur_x;
                c.y  = cur_y;
                c.fc = vb_count % (1 << FCW);
                c.ai = (vb_count / AD) % AF;
                exp_q.push_back(c);
            end
        end
        if (v && !was_pending) begin
            shadow_x = (ux > H_ACTIVE - CW_X) ? H_ACTIVE - CW_X : ux;
            shadow_y = (uy > V_ACTIVE - CW_Y) ? V_ACTIVE - CW_Y : uy;
            pending  = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int yy, input bit v, input int ux, input int uy);
        @(posedge sys_clk);
        #1;
        checkOutput("upd_ready", upd_ready, pending ? 0 : 1);
        checkOutput("char_x", char_x, cur_x);
        checkOutput("char_y", char_y, cur_y);
        checkOutput("frame_cnt", frame_cnt, vb_count % (1 << FCW));
        checkOutput("anim_idx", anim_idx, (vb_count / AD) % AF);
        driveCycle(yy, v, ux, uy);
    endtask

    // mode 0: no offers, 1: sparse random, 2: every cycle, 3: only in the vb_start cycle
    task automatic runFrame(input int mode);
        int n;
        bit v;
        for (int i = 0; i < 6; i++) begin
            v = (mode == 2) || (mode == 1 && $urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 478), v, $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        v = (mode == 2) || (mode == 1 && $urandom_range(0, 3) == 0);
        applyStimulus(479, v, $urandom_range(0, 1023), $urandom_range(0, 1023));
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            v = (mode == 2) || (mode == 3 && i == 0) || (mode == 1 && $urandom_range(0, 3) == 0);
            applyStimulus(480, v, $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        for (int i = 0; i < 3; i++) begin
            v = (mode == 2) || (mode == 1 && $urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(481, 524), v, $urandom_range(0, 1023), $urandom_range(0, 1023));
        end
    endtask

    // Scoreboard monitor: every commit_pulse must match the oldest predicted commit
    always @(negedge sys_clk) begin
        if (sys_rst_n && commit_pulse) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_commit", 1, 0);
            end else begin
                commit_t c;
                c = exp_q.pop_front();
                checkOutput("commit_x", char_x, c.x);
                checkOutput("commit_y", char_y, c.y);
                checkOutput("commit_frame_cnt", frame_cnt, c.fc);
                checkOutput("commit_anim_idx", anim_idx, c.ai);
            end
        end
    end

    initial begin
        int guard;
        modelReset();
        repeat (3) @(posedge sys_clk);
        #1;
        checkResetValues("reset");
        sys_rst_n = 1'b1;
        driveCycle(100, 0, 0, 0);

        runFrame(0);

        applyStimulus(200, 1, 100, 50);
        runFrame(0);

        applyStimulus(150, 1, 700, 470);
        runFrame(0);

        runFrame(2);
        runFrame(2);
        runFrame(0);

        runFrame(3);
        runFrame(0);

        guard = 0;
        while (vb_count < 64 && guard < 200) begin
            runFrame(1);
            guard++;
        end
        applyStimulus(100, 0, 0, 0);
        applyStimulus(100, 0, 0, 0);
        checkOutput("frame_cnt_64", frame_cnt, 64);
        checkOutput("anim_idx_64", anim_idx, 0);

        applyStimulus(120, 1, 400, 300);
        applyStimulus(130, 0, 0, 0);
        #3;
        sys_rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        modelReset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        driveCycle(100, 0, 0, 0);
        runFrame(0);
        runFrame(0);

        applyStimulus(100, 0, 0, 0);
        applyStimulus(100, 0, 0, 0);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
